// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for the five-stage Y86-64 pipe: stall/bubble/set_cc generation,
// run-state FSM, a valid-bit shadow of D/E/M/W and performance counters.
module pipe_hazard_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       E_dstM,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic             e_Cnd,
  input  logic [1:0]       m_stat,
  input  logic [1:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             E_stall,
  output logic             M_stall,
  output logic             W_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             set_cc,
  output logic [1:0]       cpu_stat,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam logic [3:0] IMrmovq = 4'h5;
  localparam logic [3:0] IOpq    = 4'h6;
  localparam logic [3:0] IJxx    = 4'h7;
  localparam logic [3:0] IRet    = 4'h9;
  localparam logic [3:0] IPopq   = 4'hB;
  localparam logic [3:0] RNone   = 4'hF;
  localparam logic [1:0] SAok    = 2'b00;
  localparam logic [1:0] SHlt    = 2'b01;

  typedef enum logic [1:0] {StIdle, StRun, StHalt, StErr} state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [1:0]       r_cpu_stat;
  logic             r_v_d, r_v_e, r_v_m, r_v_w;
  logic [CNT_W-1:0] r_cycle_cnt, r_retire_cnt, r_stall_cnt, r_mispred_cnt;

  logic w_lu, w_mp, w_rt, w_wbad, w_mbad, w_run;

  assign w_lu   = ((E_icode == IMrmovq) || (E_icode == IPopq)) && (E_dstM != RNone) &&
                  ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign w_mp   = (E_icode == IJxx) && !e_Cnd;
  assign w_rt   = (D_icode == IRet) || (E_icode == IRet) || (M_icode == IRet);
  assign w_wbad = (W_stat != SAok);
  assign w_mbad = (m_stat != SAok);
  assign w_run  = (r_state == StRun);

  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (go) w_state_nxt = StRun;
      StRun: begin
        if (W_stat == SHlt) w_state_nxt = StHalt;
        else if (w_wbad)    w_state_nxt = StErr;
      end
      StHalt:  w_state_nxt = StHalt;
      StErr:   w_state_nxt = StErr;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    E_stall  = 1'b0;
    M_stall  = 1'b0;
    W_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    set_cc   = 1'b0;
    unique case (r_state)
      StIdle: begin
        F_stall  = 1'b1;
        D_bubble = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
      end
      StRun: begin
        F_stall  = w_lu | w_rt;
        D_stall  = w_lu;
        // load-use stall takes precedence over the ret bubble in D
        D_bubble = w_mp | (w_rt & !w_lu);
        E_bubble = w_mp | w_lu;
        M_bubble = w_mbad | w_wbad;
        W_stall  = w_wbad;
        set_cc   = (E_icode == IOpq) & !w_mbad & !w_wbad;
      end
      default: begin
        F_stall = 1'b1;
        D_stall = 1'b1;
        E_stall = 1'b1;
        M_stall = 1'b1;
        W_stall = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                  r_cpu_stat <= SAok;
    else if (w_run && w_wbad) r_cpu_stat <= W_stat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v_d         <= 1'b0;
      r_v_e         <= 1'b0;
      r_v_m         <= 1'b0;
      r_v_w         <= 1'b0;
      r_cycle_cnt   <= '0;
      r_retire_cnt  <= '0;
      r_stall_cnt   <= '0;
      r_mispred_cnt <= '0;
    end else if (w_run) begin
      r_v_d         <= D_stall ? r_v_d : !D_bubble;
      r_v_e         <= E_bubble ? 1'b0 : r_v_d;
      r_v_m         <= M_bubble ? 1'b0 : r_v_e;
      r_v_w         <= W_stall ? r_v_w : r_v_m;
      r_cycle_cnt   <= r_cycle_cnt + CNT_W'(1);
      if (r_v_w && !w_wbad) r_retire_cnt  <= r_retire_cnt + CNT_W'(1);
      if (w_lu)             r_stall_cnt   <= r_stall_cnt + CNT_W'(1);
      if (w_mp)             r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
    end
  end

  assign cpu_stat    = r_cpu_stat;
  assign halted      = (r_state == StHalt) || (r_state == StErr);
  assign cycle_cnt   = r_cycle_cnt;
  assign retire_cnt  = r_retire_cnt;
  assign stall_cnt   = r_stall_cnt;
  assign mispred_cnt = r_mispred_cnt;

endmodule
